ofs_plat_prim_fifo_enq_arb: RTL



---
 rtl/ofs_plat_prim_fifo_enq_arb_if.sv | 15 +
 rtl/ofs_plat_prim_fifo_enq_arb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ofs_plat_prim_fifo_enq_arb_if.sv
// rtl/ofs_plat_prim_fifo_enq_arb_if.sv - requester-side handshake bundle for the FIFO enqueue arbiter
interface ofs_plat_prim_fifo_enq_arb_if #(
  parameter int N_REQ = 4,
  parameter int N_DATA_BITS = 32
);
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ*N_DATA_BITS-1:0] req_data;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;

  // Requesters drive beats and observe ready.
  modport master (output req_valid, req_data, req_last, input req_ready);
  // The arbiter consumes beats and returns ready.
  modport slave (input req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/ofs_plat_prim_fifo_enq_arb.sv
// rtl/ofs_plat_prim_fifo_enq_arb.sv - round-robin packet-atomic arbiter onto one FIFO enqueue port
module ofs_plat_prim_fifo_enq_arb #(
  parameter int N_REQ = 4,
  parameter int N_DATA_BITS = 32,
  parameter int MAX_PKT_BEATS = 64,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  ofs_plat_prim_fifo_enq_arb_if.slave req,
  output logic [N_DATA_BITS-1:0] fifo_enq_data,
  output logic                   fifo_enq_en,
  input  logic                   fifo_almostFull,
  input  logic                   fifo_notFull,
  output logic [OW-1:0]          grant_owner,
  output logic                   locked,
  output logic                   pkt_err
);

  localparam int CW = $clog2(MAX_PKT_BEATS + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PKT_BEATS);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_PKT_BEATS + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]             state;
  logic [OW-1:0]          rr_ptr;
  logic [CW-1:0]          beat_cnt;

  logic [OW-1:0]          win_idx;
  logic                   win_found;
  logic [OW-1:0]          sel_idx;
  logic                   sel_active;
  logic [N_DATA_BITS-1:0] sel_data;
  logic                   sel_last;
  logic                   accept;
  logic [OW-1:0]          next_ptr;
  logic [CW-1:0]          cnt_inc;

  logic                   pend_q;
  logic [OW-1:0]          pend_idx;
  logic [N_DATA_BITS-1:0] pend_data;

  assign locked = (state == ST_LOCKED);

  // Rotating priority search starting at rr_ptr for the idle-state winner.
  always_comb begin
    int idx;
    idx = 0;
    win_idx = '0;
    win_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && req.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx = OW'(idx);
      end
    end
  end

  // Select the lock owner or the idle winner; only it may see ready, gated by almostFull.
  always_comb begin
    sel_idx    = locked ? grant_owner : win_idx;
    sel_active = locked ? 1'b1 : win_found;
    sel_data   = req.req_data[sel_idx*N_DATA_BITS +: N_DATA_BITS];
    sel_last   = req.req_last[sel_idx];
    req.req_ready = '0;
    if (!reset && sel_active && !fifo_almostFull) begin
      req.req_ready[sel_idx] = 1'b1;
    end
    accept   = |(req.req_ready & req.req_valid);
    next_ptr = OW'((int'(sel_idx) + 1) % N_REQ);
    cnt_inc  = (beat_cnt >= CNT_SAT) ? beat_cnt : beat_cnt + CNT_ONE;
  end

  // Arbitration state, beat counting and the registered enqueue stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      grant_owner   <= '0;
      pkt_err       <= 1'b0;
      fifo_enq_en   <= 1'b0;
      fifo_enq_data <= '0;
    end else begin
      fifo_enq_en <= accept;
      if (accept) begin
        fifo_enq_data <= sel_data;
        grant_owner   <= sel_idx;
        if (state == ST_IDLE) begin
          if (sel_last) begin
            rr_ptr <= next_ptr;
          end else begin
            state    <= ST_LOCKED;
            beat_cnt <= CNT_ONE;
            if (CNT_ONE > CNT_MAX) pkt_err <= 1'b1;
          end
        end else begin
          if (cnt_inc > CNT_MAX) pkt_err <= 1'b1;
          if (sel_last) begin
            state    <= ST_IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= cnt_inc;
          end
        end
      end
    end
  end

  // Protocol watchdogs: no enqueue into a full FIFO, and a presented beat must hold until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= sel_active && req.req_valid[sel_idx] && !accept;
      if (fifo_enq_en) begin
        assert (fifo_notFull) else $fatal(1, "enq_en while FIFO full");
      end
      if (pend_q) begin
        assert (req.req_valid[pend_idx] &&
                req.req_data[pend_idx*N_DATA_BITS +: N_DATA_BITS] == pend_data)
          else $fatal(1, "requester %0d changed beat before accept", pend_idx);
      end
    end
    pend_idx  <= sel_idx;
    pend_data <= sel_data;
  end

endmodule
